pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 97 +++++++++
 tb/tb_pc_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction fetch FSM, one outstanding imem request, IF/ID output registers.
// FETCH_MISALIGN_TRAP_EN: misaligned redirects raise sticky misalign_err and park the FSM.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_en,
  input  logic [31:0] EX_MEM_PC,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_IR,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_NPC,
  output logic        IF_ID_valid,
  output logic        misalign_err
);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;
  state_t r_state, w_state;
  logic [31:0] r_pc, w_pc, r_ir, w_ir, r_ipc, w_ipc, r_npc, w_npc;
  logic r_valid, w_valid, r_discard, w_discard, r_err, w_err;
  logic w_req, w_pend, w_bad;
  // A stale response is still owed once this cycle ends
  assign w_req = r_state == FETCH && !r_discard;
  assign w_pend = w_req || ((r_state == WAIT || r_discard) && !imem_rvalid);
`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_bad = EX_MEM_PC[1:0] != 2'b00;
  assign misalign_err = r_err;
`else
  assign w_bad = 1'b0;
  assign misalign_err = 1'b0;
`endif
  assign imem_req = w_req;
  assign imem_addr = w_req ? r_pc : 32'h0;
  assign IF_ID_IR = r_ir;
  assign IF_ID_PC = r_ipc;
  assign IF_ID_NPC = r_npc;
  assign IF_ID_valid = r_valid;
  always_comb begin
    w_state = r_state;
    w_pc = r_pc;
    w_ir = r_ir;
    w_ipc = r_ipc;
    w_npc = r_npc;
    w_valid = r_valid;
    w_discard = r_discard && !imem_rvalid;
    w_err = r_err || (br_en && w_bad);
    if (br_en) begin
      w_valid = 1'b0;
      w_discard = w_pend;
      w_state = (w_bad || r_err) ? IDLE : FETCH;
      w_pc = w_bad ? r_pc : EX_MEM_PC & 32'hFFFF_FFFC;
    end else begin
      case (r_state)
        IDLE: w_state = r_err ? IDLE : FETCH;
        FETCH: w_state = r_discard ? FETCH : WAIT;
        WAIT: if (imem_rvalid && !r_discard) begin
          w_ir = imem_rdata;
          w_ipc = r_pc;
          w_npc = r_pc + 32'd4;
          w_pc = r_pc + 32'd4;
          w_valid = 1'b1;
          w_state = HOLD;
        end
        HOLD: if (!stall) begin
          w_valid = 1'b0;
          w_state = FETCH;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc <= RESET_PC;
      // Any request issued or awaited at reset still gets a late response
      r_discard <= (r_state == FETCH || r_state == WAIT) && !imem_rvalid;
      r_ir <= 32'h0000_0013;
      r_ipc <= 32'h0;
      r_npc <= 32'h0;
      r_valid <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pc <= w_pc;
      r_discard <= w_discard;
      r_ir <= w_ir;
      r_ipc <= w_ipc;
      r_npc <= w_npc;
      r_valid <= w_valid;
      r_err <= w_err;
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scoreboard bench with a variable-latency instruction memory model.
module tb_pc_fetch_unit;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif
  logic clk, rst, br_en, stall, imem_rvalid;
  logic [31:0] EX_MEM_PC, imem_rdata;
  logic imem_req, IF_ID_valid, misalign_err;
  logic [31:0] imem_addr, IF_ID_IR, IF_ID_PC, IF_ID_NPC;
  logic d1_req, d1_valid, d1_err;
  logic [31:0] d1_addr, d1_ir, d1_pc, d1_npc;
  int n_chk = 0;
  int n_fail = 0;
  int lat;
  logic [31:0] q_addr[$], q_pc[$], q1[$];

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .br_en(br_en), .EX_MEM_PC(EX_MEM_PC), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_ID_IR(IF_ID_IR), .IF_ID_PC(IF_ID_PC), .IF_ID_NPC(IF_ID_NPC), .IF_ID_valid(IF_ID_valid),
    .misalign_err(misalign_err)
  );
  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst), .br_en(br_en), .EX_MEM_PC(EX_MEM_PC), .stall(stall),
    .imem_req(d1_req), .imem_addr(d1_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_ID_IR(d1_ir), .IF_ID_PC(d1_pc), .IF_ID_NPC(d1_npc), .IF_ID_valid(d1_valid),
    .misalign_err(d1_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h00A0_0093;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ir"}, IF_ID_IR, 32'h0000_0013);
    chk({tag, "_pc"}, IF_ID_PC, 32'h0);
    chk({tag, "_npc"}, IF_ID_NPC, 32'h0);
    chk1({tag, "_valid"}, IF_ID_valid, 1'b0);
    chk1({tag, "_req"}, imem_req, 1'b0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk1({tag, "_err"}, misalign_err, 1'b0);
  endtask

  task automatic wait_req(input int lim);
    int k = 0;
    do begin @(negedge clk); k++; end while (!imem_req && k < lim);
    chk1("wait_req_timeout", imem_req, 1'b1);
  endtask

  task automatic wait_load(input logic [31:0] pc, input int lim);
    int k = 0;
    do begin @(negedge clk); k++; end while (!(IF_ID_valid && IF_ID_PC == pc) && k < lim);
    chk1("wait_load_timeout", IF_ID_valid && IF_ID_PC == pc, 1'b1);
  endtask

  // Memory model: one response lat cycles after each request
  initial begin
    int cnt;
    logic [31:0] a;
    cnt = 0;
    a = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = instr(a);
        end
      end
      if (imem_req) begin
        cnt = lat;
        a = imem_addr;
      end
    end
  end

  // Request scoreboard for both instances
  initial forever begin
    @(negedge clk);
    if (imem_req) begin
      chk1("req_expected", q_addr.size() > 0, 1'b1);
      if (q_addr.size() > 0) chk("req_addr", imem_addr, q_addr.pop_front());
    end
    if (d1_req && q1.size() > 0) chk("wrap_req_addr", d1_addr, q1.pop_front());
  end

  // Load scoreboard: fires on each rising IF_ID_valid
  initial begin
    logic prev;
    logic [31:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (IF_ID_valid === 1'b1 && !prev) begin
        chk1("load_expected", q_pc.size() > 0, 1'b1);
        if (q_pc.size() > 0) begin
          e = q_pc.pop_front();
          chk("load_pc", IF_ID_PC, e);
          chk("load_npc", IF_ID_NPC, e + 32'd4);
          chk("load_ir", IF_ID_IR, instr(e));
        end
      end
      prev = IF_ID_valid === 1'b1;
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    br_en = 1'b0;
    EX_MEM_PC = 32'h0;
    stall = 1'b0;
    lat = 1;
    for (int i = 0; i <= 4; i++) begin
      q_addr.push_back(32'(4 * i));
      q_pc.push_back(32'(4 * i));
    end
    q1.push_back(32'hFFFF_FFFC);
    q1.push_back(32'h0);
    q1.push_back(32'h4);
    repeat (2) @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;
    wait_load(32'h0, 20);
    chk("wrap_load_pc", d1_pc, 32'hFFFF_FFFC);
    chk("wrap_load_npc", d1_npc, 32'h0);
    wait_load(32'h10, 40);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("hold_valid", IF_ID_valid, 1'b1);
      chk("hold_pc", IF_ID_PC, 32'h10);
      chk("hold_ir", IF_ID_IR, instr(32'h10));
      chk1("hold_noreq", imem_req, 1'b0);
    end
    chk("wrap_q_empty", 32'(q1.size()), 32'd0);
    stall = 1'b0;
    lat = 3;
    q_addr.push_back(32'h14);
    wait_req(10);
    @(negedge clk);
    br_en = 1'b1;
    EX_MEM_PC = 32'h200;
    q_addr.push_back(32'h200);
    q_pc.push_back(32'h200);
    @(negedge clk);
    br_en = 1'b0;
    chk1("stale_wait0", imem_req, 1'b0);
    @(negedge clk);
    chk1("stale_wait1", imem_req, 1'b0);
    @(negedge clk);
    chk1("redirect_req", imem_req, 1'b1);
    wait_load(32'h200, 20);
    stall = 1'b1;
    lat = 1;
    chk("redirect_npc", IF_ID_NPC, 32'h204);
    @(negedge clk);
    stall = 1'b0;
    q_addr.push_back(32'h204);
    wait_req(10);
    @(negedge clk);
    br_en = 1'b1;
    EX_MEM_PC = 32'h40;
    q_addr.push_back(32'h40);
    q_pc.push_back(32'h40);
    @(negedge clk);
    br_en = 1'b0;
    chk1("same_cycle_flush", IF_ID_valid, 1'b0);
    wait_load(32'h40, 20);
    stall = 1'b1;
    br_en = 1'b1;
    EX_MEM_PC = 32'h102;
    if (!TRAP) begin
      q_addr.push_back(32'h100);
      q_pc.push_back(32'h100);
    end
    @(negedge clk);
    br_en = 1'b0;
    chk1("hold_flush", IF_ID_valid, 1'b0);
    chk1("misalign_set", misalign_err, TRAP);
    repeat (10) @(negedge clk);
    chk1("misalign_sticky", misalign_err, TRAP);
    chk1("misalign_load", IF_ID_valid, !TRAP);
    chk("addr_q_mid", 32'(q_addr.size()), 32'd0);
    rst = 1'b1;
    stall = 1'b0;
    lat = 3;
    @(negedge clk);
    check_reset("rst1");
    rst = 1'b0;
    q_addr.push_back(32'h0);
    q_addr.push_back(32'h0);
    q_pc.push_back(32'h0);
    wait_req(10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("rst_stale_wait", imem_req, 1'b0);
    @(negedge clk);
    chk1("rst_refetch", imem_req, 1'b1);
    wait_load(32'h0, 20);
    chk("addr_q_end", 32'(q_addr.size()), 32'd0);
    chk("pc_q_end", 32'(q_pc.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
